sonar_ranging_ctrl: RTL and testbench

Measurement sequencer that sits directly upstream of the three-digit BCD distance counter. Each measurement period it clears the counter, fires the ultrasonic trigger pulse, and waits for the echo. While the echo is high it feeds the counter one enable strobe per millimetre of range. It then reports completion, and flags timeout or over-range, so a downstream register can capture the counter's `show` value.

---
 rtl/sonar_ranging_ctrl_pkg.sv | 24 ++
 rtl/sonar_ranging_ctrl_sync_2ff.sv | 22 ++
 rtl/sonar_ranging_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_sonar_ranging_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sonar_ranging_ctrl_pkg.sv
// Shared definitions for the sonar ranging sequencer: FSM state encodings,
// default timing constants and a counter-width helper.
package sonar_ranging_ctrl_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_CLEAR     = 3'd0;
    localparam logic [2:0] ST_TRIG      = 3'd1;
    localparam logic [2:0] ST_WAIT_RISE = 3'd2;
    localparam logic [2:0] ST_MEASURE   = 3'd3;
    localparam logic [2:0] ST_HOLD      = 3'd4;

    // Default timing at 100 MHz
    localparam int unsigned DEF_TRIG_CYCLES    = 1000;       // 10 us trigger
    localparam int unsigned DEF_TICK_CYCLES    = 583;        // 1 mm of range
    localparam int unsigned DEF_TIMEOUT_CYCLES = 3_800_000;  // 38 ms
    localparam int unsigned DEF_PERIOD_CYCLES  = 6_000_000;  // 60 ms
    localparam int unsigned DEF_MAX_COUNT      = 999;        // 3-digit BCD full scale

    // Bits needed to count 0..limit-1, never less than one
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/sonar_ranging_ctrl_sync_2ff.sv
// Two-flop synchronizer for the asynchronous echo input, resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the asynchronous input into the clk domain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sonar_ranging_ctrl.sv
// Sonar measurement sequencer: clears the distance counter, fires the trigger,
// times the echo and issues one count strobe per millimetre of range.
module sonar_ranging_ctrl
    import sonar_ranging_ctrl_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int unsigned TICK_CYCLES    = DEF_TICK_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
    parameter int unsigned MAX_COUNT      = DEF_MAX_COUNT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic echo,
    output logic trig,
    output logic cnt_clr,
    output logic cnt_ena,
    output logic done,
    output logic timeout,
    output logic over_range
);

    localparam int unsigned TRW = cnt_width(TRIG_CYCLES);
    localparam int unsigned DW  = cnt_width(TICK_CYCLES);
    localparam int unsigned WW  = cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned PW  = cnt_width(PERIOD_CYCLES);
    localparam int unsigned SW  = cnt_width(MAX_COUNT + 1);

    localparam logic [TRW-1:0] TRIG_LAST  = TRW'(TRIG_CYCLES - 1);
    localparam logic [DW-1:0]  DIV_LAST   = DW'(TICK_CYCLES - 1);
    localparam logic [WW-1:0]  WAIT_LAST  = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW-1:0]  PER_LAST   = PW'(PERIOD_CYCLES - 1);
    localparam logic [SW-1:0]  STROBE_MAX = SW'(MAX_COUNT);
    localparam logic [SW-1:0]  STROBE_PRE = SW'(MAX_COUNT - 1);

    logic           echo_s;
    logic           echo_d;
    logic           rise;
    logic           fall;
    logic [2:0]     state;
    logic [2:0]     state_nxt;
    logic           started;
    logic           pend;
    logic [TRW-1:0] trig_cnt;
    logic [DW-1:0]  div_cnt;
    logic [WW-1:0]  wait_cnt;
    logic [PW-1:0]  per_cnt;
    logic [SW-1:0]  strobes;
    logic           per_wrap;
    logic           div_last;
    logic           wait_last;
    logic           tick_now;
    logic           meas_term;
    logic           to_evt;

    sync_2ff u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (echo),
        .q       (echo_s)
    );

    assign rise      = echo_s & ~echo_d;
    assign fall      = ~echo_s & echo_d;
    assign per_wrap  = (per_cnt == PER_LAST);
    assign div_last  = (div_cnt == DIV_LAST);
    assign wait_last = (wait_cnt == WAIT_LAST);
    assign tick_now  = div_last && (strobes != STROBE_MAX);
    assign meas_term = fall || wait_last;
    assign to_evt    = ((state == ST_WAIT_RISE) && !rise && wait_last)
                    || ((state == ST_MEASURE) && !pend && !fall && wait_last);

    // Previous synchronized echo for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) echo_d <= 1'b0;
        else          echo_d <= echo_s;
    end

    // Next-state decode; the reset state is re-entered once so the first
    // cycle after release carries the clear pulse
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR:     state_nxt = started ? ST_TRIG : ST_CLEAR;
            ST_TRIG:      if (trig_cnt == TRIG_LAST) state_nxt = ST_WAIT_RISE;
            ST_WAIT_RISE: begin
                if (rise)           state_nxt = ST_MEASURE;
                else if (wait_last) state_nxt = ST_HOLD;
            end
            // A terminating event that coincides with a strobe waits one
            // cycle (pend) so done never overlaps cnt_ena
            ST_MEASURE:   if (pend || (meas_term && !tick_now)) state_nxt = ST_HOLD;
            ST_HOLD:      if (per_wrap) state_nxt = ST_CLEAR;
            default:      state_nxt = ST_CLEAR;
        endcase
    end

    // State register and first-cycle marker
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_CLEAR;
            started <= 1'b0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
        end
    end

    // Period counter, zero in the first clear cycle after reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               per_cnt <= '0;
        else if (!started || per_wrap) per_cnt <= '0;
        else                        per_cnt <= per_cnt + PW'(1);
    end

    // Phase counters: trigger length, echo wait, tick divider and strobe count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_cnt <= '0;
            wait_cnt <= '0;
            div_cnt  <= '0;
            strobes  <= '0;
            pend     <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    trig_cnt <= '0;
                    strobes  <= '0;
                    pend     <= 1'b0;
                end
                ST_TRIG: begin
                    if (trig_cnt == TRIG_LAST) wait_cnt <= '0;
                    else                       trig_cnt <= trig_cnt + TRW'(1);
                end
                ST_WAIT_RISE: begin
                    if (rise) begin
                        wait_cnt <= '0;
                        div_cnt  <= '0;
                        strobes  <= '0;
                    end else if (!wait_last) begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                ST_MEASURE: begin
                    if (pend) begin
                        pend <= 1'b0;
                    end else begin
                        div_cnt <= div_last ? '0 : div_cnt + DW'(1);
                        if (!wait_last) wait_cnt <= wait_cnt + WW'(1);
                        if (tick_now)   strobes  <= strobes + SW'(1);
                        pend <= tick_now && meas_term;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs and sticky status
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig       <= 1'b0;
            cnt_clr    <= 1'b0;
            cnt_ena    <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            over_range <= 1'b0;
        end else begin
            trig    <= (state_nxt == ST_TRIG);
            cnt_clr <= (state_nxt == ST_CLEAR);
            cnt_ena <= (state == ST_MEASURE) && !pend && tick_now;
            done    <= (state != ST_HOLD) && (state_nxt == ST_HOLD);
            if (state_nxt == ST_CLEAR) begin
                timeout    <= 1'b0;
                over_range <= 1'b0;
            end else begin
                if (to_evt) timeout <= 1'b1;
                if ((state == ST_MEASURE) && !pend && tick_now && (strobes == STROBE_PRE))
                    over_range <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sonar_ranging_ctrl.sv
// Self-checking bench for sonar_ranging_ctrl: directed and random echo
// pulses per measurement period, checked against a range-equation model.
module tb_sonar_ranging_ctrl;

    localparam int TRIG = 10;
    localparam int TICK = 4;
    localparam int TO   = 100;
    localparam int PER  = 300;
    localparam int MAXC = 20;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic echo = 1'b0;
    logic trig, cnt_clr, cnt_ena, done, timeout, over_range;

    int checks = 0;
    int failures = 0;

    sonar_ranging_ctrl #(
        .TRIG_CYCLES    (TRIG),
        .TICK_CYCLES    (TICK),
        .TIMEOUT_CYCLES (TO),
        .PERIOD_CYCLES  (PER),
        .MAX_COUNT      (MAXC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .echo       (echo),
        .trig       (trig),
        .cnt_clr    (cnt_clr),
        .cnt_ena    (cnt_ena),
        .done       (done),
        .timeout    (timeout),
        .over_range (over_range)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] outs();
        return {26'd0, trig, cnt_clr, cnt_ena, done, timeout, over_range};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One measurement period, first sampled cycle is the cnt_clr cycle (k=0).
    // Echo pin is high for h cycles starting d cycles after WAIT_RISE entry.
    task automatic run_period(input string name, input int d, input int h, input int abort_at);
        int w, c, m, endc, defer;
        int n_exp, done_exp, to_exp, ov_exp, ena1_exp;
        int clr_cnt, trig_cnt, trig_first, ena_cnt, ena_first;
        int done_cnt, done_at, to_at, ov_at, ena_late;
        logic [31:0] to0, ov0;

        // Spec-level expectation
        w = TRIG + 1;
        c = w + d;
        if (h > 0 && (c + 2) >= w && (c + 2) <= w + TO - 1) begin
            m = c + 3;
            if (h <= TO) begin
                n_exp  = (h / TICK < MAXC) ? h / TICK : MAXC;
                endc   = m + h - 1;
                defer  = (h % TICK == 0 && h / TICK <= MAXC) ? 1 : 0;
                to_exp = 0;
            end else begin
                n_exp  = (TO / TICK < MAXC) ? TO / TICK : MAXC;
                endc   = m + TO - 1;
                defer  = (TO % TICK == 0 && TO / TICK <= MAXC) ? 1 : 0;
                to_exp = 1;
            end
            done_exp = endc + 1 + defer;
            ena1_exp = (n_exp > 0) ? m + TICK : -1;
        end else begin
            n_exp    = 0;
            done_exp = w + TO;
            to_exp   = 1;
            ena1_exp = -1;
        end
        ov_exp = (n_exp == MAXC) ? 1 : 0;

        clr_cnt = 0; trig_cnt = 0; trig_first = -1; ena_cnt = 0; ena_first = -1;
        done_cnt = 0; done_at = -1; to_at = -1; ov_at = -1; ena_late = 0;
        to0 = '0; ov0 = '0;

        for (int k = 0; k < PER; k++) begin
            @(negedge clk);
            if (k == 0) begin
                to0 = {31'd0, timeout};
                ov0 = {31'd0, over_range};
                check({name, ":clr_at_start"}, {31'd0, cnt_clr}, 1);
            end
            if (cnt_clr) clr_cnt++;
            if (trig) begin
                trig_cnt++;
                if (trig_first < 0) trig_first = k;
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = k;
                    to_at   = int'(timeout);
                    ov_at   = int'(over_range);
                end
            end
            if (cnt_ena) begin
                ena_cnt++;
                if (ena_first < 0) ena_first = k;
                if (done_at >= 0) ena_late++;
            end
            if (k == abort_at) begin
                #2 reset_n = 1'b0;
                echo = 1'b0;
                #1 check({name, ":async_reset_outs"}, outs(), 0);
                return;
            end
            echo = (h > 0 && k >= c && k < c + h);
        end

        check({name, ":timeout_cleared"}, to0, 0);
        check({name, ":over_cleared"}, ov0, 0);
        check({name, ":clr_cycles"}, clr_cnt, 1);
        check({name, ":trig_first"}, trig_first, 1);
        check({name, ":trig_len"}, trig_cnt, TRIG);
        check({name, ":ena_count"}, ena_cnt, n_exp);
        check({name, ":ena_first"}, ena_first, ena1_exp);
        check({name, ":done_count"}, done_cnt, 1);
        check({name, ":done_cycle"}, done_at, done_exp);
        check({name, ":timeout"}, to_at, to_exp);
        check({name, ":over_range"}, ov_at, ov_exp);
        check({name, ":ena_after_done"}, ena_late, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rd, rh;

        // Outputs held low while in reset
        repeat (3) begin
            @(negedge clk);
            check("reset_outs", outs(), 0);
        end
        reset_n = 1'b1;

        run_period("echo43",      2,  43, -1);
        run_period("no_echo",     0,   0, -1);
        run_period("over95",      4,  95, -1);
        run_period("held150",     0, 150, -1);
        run_period("after_held",  1,  30, -1);
        run_period("early_rise", -5,  40, -1);
        run_period("rise_first", -2,  12, -1);
        run_period("rise_last",  TO - 3, 10, -1);
        run_period("rise_late",  TO - 2, 10, -1);
        run_period("h80_defer",   3,  80, -1);
        run_period("h84",         3,  84, -1);
        run_period("h4_defer",    6,   4, -1);
        run_period("h3",          6,   3, -1);
        run_period("h100",        2, TO, -1);
        run_period("h101",        2, TO + 1, -1);

        for (int i = 0; i < 8; i++) begin
            rd = int'($urandom_range(118, 0)) - 8;
            rh = int'($urandom_range(160, 1));
            run_period($sformatf("rand%0d_d%0d_h%0d", i, rd, rh), rd, rh, -1);
        end

        // Reset mid-measurement after over_range has been raised
        run_period("abort", 3, 120, TRIG + 1 + 3 + 3 + 85);
        repeat (3) begin
            @(negedge clk);
            check("abort_reset_outs", outs(), 0);
        end
        reset_n = 1'b1;
        run_period("post_abort", 2, 43, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
